// File: rtl/spi_pkg.sv
// Shared SPI link constants and the receiver state encoding.
// The transmitter control unit imports the same constants so both ends agree on framing.
package spi_pkg;

  typedef enum logic [1:0] {
    s_IDLE = 2'd0,
    s_RECV = 2'd1,
    s_HOLD = 2'd2
  } spi_rx_state_t;

  localparam int SPI_DATA_W      = 8;
  localparam int SPI_FRAME_LEN   = 5;
  localparam int SPI_ADDR_W      = 3;
  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, followed by rise/fall detection.
// Edges are flagged for exactly one i_clock cycle: the first cycle the synced level differs
// from its previous registered value.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int             DW      = 1,
  parameter int             STAGES  = SPI_SYNC_STAGES,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          i_clock,
  input  logic          i_rst_n,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] sync,
  output logic [DW-1:0] rise,
  output logic [DW-1:0] fall
);

  logic [DW-1:0] stage_r [STAGES];
  logic [DW-1:0] prev_r;

  // Synchronizer chain plus one extra register holding the previous synced level.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= RST_VAL;
      end
      prev_r <= RST_VAL;
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
      prev_r <= stage_r[STAGES-1];
    end
  end

  assign sync = stage_r[STAGES-1];
  assign rise = sync & ~prev_r;
  assign fall = ~sync & prev_r;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver, MSB first. Each completed word is written to a register file at
// its index within the CS_N-low frame; the frame ends with a done pulse, or an error pulse if
// CS_N rises early. Words after the last index are ignored until CS_N rises.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int FRAME_LEN   = SPI_FRAME_LEN,
  parameter int ADDR_W      = SPI_ADDR_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              i_clock,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_mosi,
  input  logic              i_cs_n,
  output logic [DATA_W-1:0] o_wdata,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_we,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int                BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(FRAME_LEN - 1);

  // Synchronized SPI inputs and their edge flags.
  logic sclk_rise_s;
  logic sclk_sync_unused_s;
  logic sclk_fall_unused_s;
  logic cs_n_sync_s;
  logic cs_rise_s;
  logic cs_fall_s;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic mosi_s;

  // Receiver state and counters.
  spi_rx_state_t     state_r, state_next_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_next_s;
  logic [ADDR_W-1:0] word_cnt_r, word_cnt_next_s;
  logic [DATA_W-1:0] shift_r, shift_next_s;

  // Next values of the registered outputs.
  logic [DATA_W-1:0] wdata_next_s;
  logic [ADDR_W-1:0] waddr_next_s;
  logic              we_next_s;
  logic              done_next_s;
  logic              err_next_s;
  logic              busy_next_s;

  spi_sync_edge #(
    .DW      (1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .i_clock (i_clock),
    .i_rst_n (i_rst_n),
    .din     (i_sclk),
    .sync    (sclk_sync_unused_s),
    .rise    (sclk_rise_s),
    .fall    (sclk_fall_unused_s)
  );

  spi_sync_edge #(
    .DW      (1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .i_clock (i_clock),
    .i_rst_n (i_rst_n),
    .din     (i_cs_n),
    .sync    (cs_n_sync_s),
    .rise    (cs_rise_s),
    .fall    (cs_fall_s)
  );

  // MOSI needs only the level, delayed by the same number of stages as SCLK so they stay aligned.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mosi_sync_r <= '0;
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_mosi};
    end
  end

  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

  // Next-state, counter, shift and output-strobe logic for the receive FSM.
  always_comb begin
    state_next_s    = state_r;
    bit_cnt_next_s  = bit_cnt_r;
    word_cnt_next_s = word_cnt_r;
    shift_next_s    = shift_r;
    wdata_next_s    = o_wdata;
    waddr_next_s    = o_waddr;
    we_next_s       = 1'b0;
    done_next_s     = 1'b0;
    err_next_s      = 1'b0;

    case (state_r)
      s_IDLE: begin
        if (cs_fall_s) begin
          state_next_s    = s_RECV;
          bit_cnt_next_s  = '0;
          word_cnt_next_s = '0;
          shift_next_s    = '0;
        end else begin
          state_next_s = s_IDLE;
        end
      end

      s_RECV: begin
        if (cs_rise_s) begin
          // Early CS_N release: any partial word is dropped.
          state_next_s = s_IDLE;
          err_next_s   = 1'b1;
        end else if (sclk_rise_s && !cs_n_sync_s) begin
          shift_next_s = {shift_r[DATA_W-2:0], mosi_s};
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_next_s = '0;
            we_next_s      = 1'b1;
            wdata_next_s   = {shift_r[DATA_W-2:0], mosi_s};
            waddr_next_s   = word_cnt_r;
            if (word_cnt_r == WORD_LAST) begin
              done_next_s     = 1'b1;
              word_cnt_next_s = '0;
              state_next_s    = s_HOLD;
            end else begin
              word_cnt_next_s = word_cnt_r + ADDR_W'(1);
            end
          end else begin
            bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          state_next_s = s_RECV;
        end
      end

      s_HOLD: begin
        // Frame already complete: ignore SCLK and CS_N glitches until CS_N rises.
        if (cs_rise_s) begin
          state_next_s = s_IDLE;
        end else begin
          state_next_s = s_HOLD;
        end
      end

      default: begin
        state_next_s = s_IDLE;
      end
    endcase

    busy_next_s = (state_next_s != s_IDLE);
  end

  // State, counters, shift register and all registered outputs.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= s_IDLE;
      bit_cnt_r    <= '0;
      word_cnt_r   <= '0;
      shift_r      <= '0;
      o_wdata      <= '0;
      o_waddr      <= '0;
      o_we         <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      bit_cnt_r    <= bit_cnt_next_s;
      word_cnt_r   <= word_cnt_next_s;
      shift_r      <= shift_next_s;
      o_wdata      <= wdata_next_s;
      o_waddr      <= waddr_next_s;
      o_we         <= we_next_s;
      o_frame_done <= done_next_s;
      o_frame_err  <= err_next_s;
      o_busy       <= busy_next_s;
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: the stimulus side pushes the expected writes as it sends
// each frame; a monitor on the falling clock edge pops and compares every o_we it sees.
module tb_spi_slave_rx;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       done;
  } exp_t;

  logic       i_clock = 1'b0;
  logic       i_rst_n;
  logic       i_sclk;
  logic       i_mosi;
  logic       i_cs_n;
  logic [7:0] o_wdata;
  logic [2:0] o_waddr;
  logic       o_we;
  logic       o_frame_done;
  logic       o_frame_err;
  logic       o_busy;

  int   total    = 0;
  int   bad      = 0;
  int   err_seen = 0;
  int   exp_err  = 0;
  exp_t sb_q[$];
  logic [7:0] frame_b [0:7];

  spi_slave_rx dut (
    .i_clock      (i_clock),
    .i_rst_n      (i_rst_n),
    .i_sclk       (i_sclk),
    .i_mosi       (i_mosi),
    .i_cs_n       (i_cs_n),
    .o_wdata      (o_wdata),
    .o_waddr      (o_waddr),
    .o_we         (o_we),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  // 10 ns system clock.
  always #5 i_clock = ~i_clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every write strobe, count error pulses.
  always @(negedge i_clock) begin
    if (i_rst_n === 1'b1) begin
      if (o_frame_err) err_seen++;
      if (o_frame_done) chk("done_with_we", {31'd0, o_we}, 32'd1);
      if (o_we) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write", o_waddr, o_wdata);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("wdata", {24'd0, o_wdata}, {24'd0, e.data});
          chk("waddr", {29'd0, o_waddr}, {29'd0, e.addr});
          chk("frame_done", {31'd0, o_frame_done}, {31'd0, e.done});
        end
      end
    end
  end

  task automatic send_bits(input logic [7:0] b, input int nbits, input int half);
    for (int k = 0; k < nbits; k++) begin
      i_mosi = b[7-k];
      #(half);
      i_sclk = 1'b1;
      #(half);
      i_sclk = 1'b0;
    end
  endtask

  // Send nbytes full words from frame_b plus extra_bits of the following word in one CS window.
  task automatic run_frame(input int nbytes, input int extra_bits, input int half);
    for (int i = 0; i < nbytes && i < 5; i++) begin
      exp_t e;
      e.addr = 3'(i);
      e.data = frame_b[i];
      e.done = (i == 4);
      sb_q.push_back(e);
    end
    i_cs_n = 1'b0;
    #(2 * half);
    for (int i = 0; i < nbytes; i++) begin
      send_bits(frame_b[i], 8, half);
    end
    if (extra_bits > 0) send_bits(frame_b[nbytes], extra_bits, half);
    #(half);
    i_cs_n = 1'b1;
    #(4 * half);
  endtask

  // Bounded wait for outstanding writes, then check scoreboard and error count.
  task automatic drain(input string name);
    for (int c = 0; c < 40; c++) begin
      if (sb_q.size() == 0) break;
      @(posedge i_clock);
    end
    @(negedge i_clock);
    chk({name, "_pending"}, 32'(sb_q.size()), 32'd0);
    chk({name, "_errs"}, 32'(err_seen), 32'(exp_err));
    sb_q.delete();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_sclk  = 1'b0;
    i_mosi  = 1'b0;
    i_cs_n  = 1'b1;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    chk("reset_outputs", {18'd0, o_wdata, o_waddr, o_we, o_frame_done, o_frame_err, o_busy}, 32'd0);
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clock);

    // 1: basic frame at i_clock/8
    frame_b[0] = 8'hA5; frame_b[1] = 8'h3C; frame_b[2] = 8'hFF;
    frame_b[3] = 8'h00; frame_b[4] = 8'h81;
    run_frame(5, 0, 40);
    drain("t1");

    // 2: abort after 2 words + 3 bits
    frame_b[0] = 8'h5A; frame_b[1] = 8'hC3; frame_b[2] = 8'hE7;
    exp_err++;
    run_frame(2, 3, 40);
    drain("t2");
    chk("t2_busy", {31'd0, o_busy}, 32'd0);

    // 3: six words in one window, last is ignored
    frame_b[0] = 8'h01; frame_b[1] = 8'h02; frame_b[2] = 8'h04;
    frame_b[3] = 8'h08; frame_b[4] = 8'h10; frame_b[5] = 8'hEE;
    run_frame(6, 0, 40);
    drain("t3");

    // 4: back-to-back frames
    for (int i = 0; i < 5; i++) frame_b[i] = 8'h11 + 8'(i);
    run_frame(5, 0, 40);
    for (int i = 0; i < 5; i++) frame_b[i] = 8'h21 + 8'(i);
    run_frame(5, 0, 40);
    drain("t4");

    // 5: reset during word 3 bit 4, then a clean frame
    frame_b[0] = 8'h9C; frame_b[1] = 8'h63; frame_b[2] = 8'hB2; frame_b[3] = 8'hD4;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.addr = 3'(i);
      e.data = frame_b[i];
      e.done = 1'b0;
      sb_q.push_back(e);
    end
    i_cs_n = 1'b0;
    #(80);
    for (int i = 0; i < 3; i++) send_bits(frame_b[i], 8, 40);
    send_bits(frame_b[3], 4, 40);
    i_mosi = frame_b[3][3];
    #(40);
    i_sclk = 1'b1;
    #(20);
    i_rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", {18'd0, o_wdata, o_waddr, o_we, o_frame_done, o_frame_err, o_busy}, 32'd0);
    #(19);
    i_sclk = 1'b0;
    #(40);
    i_cs_n = 1'b1;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    i_rst_n = 1'b1;
    repeat (4) @(posedge i_clock);
    drain("t5a");
    frame_b[0] = 8'h3E; frame_b[1] = 8'h7F; frame_b[2] = 8'h80;
    frame_b[3] = 8'hC1; frame_b[4] = 8'h55;
    run_frame(5, 0, 40);
    drain("t5b");

    // 6: SCLK at i_clock/4 with random phase
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 5; i++) frame_b[i] = 8'($urandom_range(0, 255));
      @(posedge i_clock);
      #($urandom_range(1, 9));
      run_frame(5, 0, 20);
    end
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
